flit_packet_tx: RTL and testbench
=================================

Name: flit_packet_tx

Overview:
- Transmit side of the NoC flit protocol.
- Accepts one packet request plus 1..7 payload words.
- Emits a HEAD flit, then BODY flits, then a TAIL flit, each with a 16-bit checksum.
- Waits for the matching ACK flit; retransmits the whole packet on timeout, up to a retry limit.
- Sits between the node's message source and the link/UART flit serializer.
- Its counterpart is the receive-side packet buffer, which holds 8 flits per packet.

Parameters:
- NODE_ID, 8'h00, this node's id; used as src_id and global_src_id.
- VERSION, 3'd1, value driven into flit header.version.
- ACK_TIMEOUT, 1024, cycles to wait for an ACK after the TAIL handshake.
- MAX_RETRY, 3, number of retransmissions before reporting failure.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when valid&&ready
- req_dst_id  in  8  destination node_id_t
- req_packet_id  in  8  packet_id_t
- req_length  in  8  number of payload words; legal range 1..7
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word accepted when valid&&ready
- data  in  72  payload word (body_t/tail_t data)
- flit_out_valid  out  1  outgoing flit valid
- flit_out_ready  in  1  downstream accepts the flit
- flit_out  out  128  flit_t
- ack_valid  in  1  incoming ACK candidate; always consumed
- ack_flit  in  128  flit_t
- done  out  1  one-cycle pulse when the packet finishes (success or failure)
- tx_signal  out  32  signal_t status; sticky until the next request is accepted
- state  out  4  noc_state_t

Behaviour:
- Clock and reset: single clock domain, clk. rst is asynchronous and active-high.
- Reset values: FSM=IDLE; req_ready=0 while rst is high, 1 in IDLE; data_ready=0; flit_out_valid=0; flit_out=0; done=0; tx_signal=NO_ERROR; state=NORMAL; retry count=0; timer=0.
- Reset mid-packet aborts immediately. No flit is completed; the buffer contents are don't-care.
- FSM states: IDLE, LOAD, SEND, WAIT_ACK, FINISH.
- state output mapping: WAIT_ACK -> WAIT_ACK; FINISH with failure -> ERROR for that cycle; all other states -> NORMAL.
- IDLE:
  - req_ready=1.
  - On handshake, latch dst, packet_id and length; clear tx_signal; zero retry count.
  - If length==0 or length>7: set tx_signal=GENERAL_FATAL_ERROR, go to FINISH. No flits are sent.
  - Otherwise go to LOAD.
- LOAD:
  - data_ready=1.
  - Store words into an internal 7x72 buffer at index 0..length-1.
  - After the last word's handshake, go to SEND with flit index 0.
- SEND:
  - Present flit index i, for i = 0..length.
  - flit_out must stay stable while valid && !ready.
  - Advance i on each handshake. After the handshake of i==length, load timer=ACK_TIMEOUT and go to WAIT_ACK.
  - The first flit is valid the cycle after the last data handshake.
- Header fields for flit i:
  - version=VERSION, is_ack=0, src_id=NODE_ID, dst_id=latched dst.
  - flit_id={packet_id, i}.
  - flittype: HEAD for i=0, TAIL for i=length, BODY otherwise.
- HEAD payload: global_src_id=NODE_ID, global_dst_id=dst, length=length, vc=0, header=H_NORMAL, option_flag=0, options=0.
- BODY/TAIL payload: buffer[i-1].
- Checksum: XOR of the seven 16-bit slices of flit bits [127:16].
- An ACK matches only if all hold: ack_valid=1, is_ack=1, dst_id==NODE_ID, src_id==latched dst, packet_id==latched packet_id, checksum correct.
- Non-matching ACKs, and any ACK outside WAIT_ACK, are dropped silently.
- WAIT_ACK:
  - The timer decrements each cycle.
  - Matching ACK: tx_signal=NO_ERROR, go to FINISH.
  - Timer reaches 0 and retry<MAX_RETRY: retry++, go to SEND at i=0. Data is replayed from the buffer.
  - Timer reaches 0 and retry==MAX_RETRY: tx_signal=TX_NOT_REACHABLE, go to FINISH.
  - A matching ACK in the same cycle as expiry wins.
- FINISH: done=1 for one cycle, then IDLE.

Decomposition:
- types package additions:
  - tx FSM enum.
  - MAX_PAYLOAD_FLITS = NUM_ENTRIES-1.
  - Checksum slice count constant.
  - Function flit_checksum(flit_t) returning checksum_t.
- Sub-module: flit_checksum_calc, combinational. It is shared with the receive path for both generation and checking.

Test Plan:
- length=3, dst=8'h05, pid=8'h2A, NODE_ID=8'h01, ready always 1 -> 4 consecutive flits. Types are HEAD, BODY, BODY, TAIL with flit_num 0..3. Every checksum verifies. Then a matching ACK gives done pulse and tx_signal=0.
- flit_out_ready toggled 1010 during SEND -> flit_out is held stable while stalled and no flit is duplicated or skipped.
- No ACK, MAX_RETRY=3, ACK_TIMEOUT=16 -> packet sent 4 times identically, then state=ERROR, tx_signal=32'h2, done pulse.
- Three ACK variants (wrong pid 8'h2B, bad checksum, is_ack=0) in WAIT_ACK are ignored -> retransmit still happens. A following correct ACK completes the packet.
- req_length=0 and req_length=8 -> no flits, tx_signal=32'h8000_0000, done pulse.
- rst asserted during the BODY flit -> outputs return to reset values asynchronously. After release, a new length=1 request produces a HEAD+TAIL pair with flit_num 0 and 1.

Source files
------------

// File: rtl/flit_packet_tx_pkg.sv
// Shared types for the NoC flit protocol: the flit layout, status codes,
// the transmit FSM encoding and the checksum helper.
//
// Flit layout (128 bits, MSB first):
//   [127:125] version   [124] is_ack   [123:122] flittype   [121:120] rsvd
//   [119:112] src_id    [111:104] dst_id
//   [103:96]  packet_id [95:88] flit_num          (together: flit_id)
//   [87:16]   payload (head_t for HEAD, 72-bit data word for BODY/TAIL)
//   [15:0]    checksum = XOR of the seven 16-bit slices of [127:16]
package flit_packet_tx_pkg;

    localparam int FLIT_W            = 128;
    localparam int PAYLOAD_W         = 72;
    localparam int CHECKSUM_W        = 16;
    localparam int NUM_ENTRIES       = 8;
    localparam int MAX_PAYLOAD_FLITS = NUM_ENTRIES - 1;
    localparam int CHECKSUM_SLICES   = (FLIT_W - CHECKSUM_W) / CHECKSUM_W;

    typedef logic [7:0]            node_id_t;
    typedef logic [7:0]            packet_id_t;
    typedef logic [CHECKSUM_W-1:0] checksum_t;
    typedef logic [PAYLOAD_W-1:0]  body_t;

    typedef enum logic [1:0] {
        FT_HEAD = 2'd0,
        FT_BODY = 2'd1,
        FT_TAIL = 2'd2,
        FT_ACK  = 2'd3
    } flittype_t;

    typedef enum logic [7:0] {
        H_NORMAL = 8'h00
    } header_type_t;

    typedef enum logic [31:0] {
        NO_ERROR            = 32'h0000_0000,
        TX_NOT_REACHABLE    = 32'h0000_0002,
        GENERAL_FATAL_ERROR = 32'h8000_0000
    } signal_t;

    typedef enum logic [3:0] {
        NORMAL   = 4'd0,
        WAIT_ACK = 4'd1,
        ERROR    = 4'd2
    } noc_state_t;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_LOAD     = 3'd1,
        TX_SEND     = 3'd2,
        TX_WAIT_ACK = 3'd3,
        TX_FINISH   = 3'd4
    } tx_fsm_t;

    typedef struct packed {
        logic [2:0] version;
        logic       is_ack;
        flittype_t  flittype;
        logic [1:0] rsvd;
        node_id_t   src_id;
        node_id_t   dst_id;
        packet_id_t packet_id;
        logic [7:0] flit_num;
    } header_t;

    typedef struct packed {
        node_id_t     global_src_id;
        node_id_t     global_dst_id;
        logic [7:0]   length;
        logic [7:0]   vc;
        header_type_t header;
        logic         option_flag;
        logic [30:0]  options;
    } head_t;

    typedef struct packed {
        header_t   hdr;
        body_t     payload;
        checksum_t checksum;
    } flit_t;

    // XOR of every 16-bit slice above the checksum field itself.
    function automatic checksum_t flit_checksum(flit_t f);
        logic [FLIT_W-1:0] bits;
        checksum_t         c;
        bits = f;
        c    = '0;
        for (int s = 0; s < CHECKSUM_SLICES; s++) begin
            c = c ^ bits[CHECKSUM_W*(s+1) +: CHECKSUM_W];
        end
        return c;
    endfunction

endpackage

// File: rtl/flit_packet_tx_checksum_calc.sv
// flit_checksum_calc: combinational checksum of a flit. The checksum field
// of the input is ignored, so the same block generates a checksum for an
// outgoing flit and recomputes one to check against an incoming flit.
//   i_flit     : flit to checksum
//   o_checksum : XOR of the seven 16-bit slices of i_flit[127:16]
module flit_checksum_calc
    import flit_packet_tx_pkg::*;
(
    input  flit_t     i_flit,
    output checksum_t o_checksum
);

    assign o_checksum = flit_checksum(i_flit);

endmodule

// File: rtl/flit_packet_tx.sv
// flit_packet_tx: transmit side of the NoC flit protocol.
// Takes one packet request plus 1..7 payload words, emits HEAD, BODY..., TAIL
// flits with checksums, then waits for the matching ACK. On ACK timeout the
// whole packet is replayed from the internal buffer, up to MAX_RETRY times.
//
// Handshakes (req, data, flit_out): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holds valid and its payload
// stable until the transfer; ready may change freely.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : packet request (dst, packet id, length 1..7)
//   data_valid/ready  : payload words, one per handshake
//   data              : 72-bit payload word
//   flit_out_*        : outgoing flit stream
//   ack_valid/ack_flit: incoming ACK candidates, consumed every cycle
//   done              : one-cycle pulse when a packet finishes
//   tx_signal         : sticky status of the last packet
//   state             : NORMAL / WAIT_ACK / ERROR
//   dbg_fsm           : raw FSM state for observation
module flit_packet_tx
    import flit_packet_tx_pkg::*;
#(
    parameter node_id_t   NODE_ID     = 8'h00,
    parameter logic [2:0] VERSION     = 3'd1,
    parameter int         ACK_TIMEOUT = 1024,
    parameter int         MAX_RETRY   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [7:0]   req_dst_id,
    input  logic [7:0]   req_packet_id,
    input  logic [7:0]   req_length,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic [71:0]  data,
    output logic         flit_out_valid,
    input  logic         flit_out_ready,
    output logic [127:0] flit_out,
    input  logic         ack_valid,
    input  logic [127:0] ack_flit,
    output logic         done,
    output logic [31:0]  tx_signal,
    output logic [3:0]   state,
    output logic [2:0]   dbg_fsm
);

    localparam int TIMER_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    tx_fsm_t             r_fsm;
    tx_fsm_t             w_fsm_nxt;
    node_id_t            r_dst;
    packet_id_t          r_pid;
    logic [2:0]          r_len;
    logic [2:0]          r_idx;
    logic [TIMER_W-1:0]  r_timer;
    logic [RETRY_W-1:0]  r_retry;
    signal_t             r_sig;
    body_t               r_buf [MAX_PAYLOAD_FLITS];

    logic      w_req_ready;
    logic      w_data_ready;
    logic      w_flit_valid;
    logic      w_done;
    logic      w_len_ok;
    logic      w_load_last;
    logic      w_send_last;
    logic      w_expire;
    logic      w_retry_done;
    logic      w_ack_match;
    head_t     w_head;
    flit_t     w_flit;
    flit_t     w_ack;
    checksum_t w_flit_cks;
    checksum_t w_ack_cks;

    assign w_len_ok     = (req_length != 8'd0) && (req_length <= 8'(MAX_PAYLOAD_FLITS));
    assign w_load_last  = (r_idx == r_len - 3'd1);
    assign w_send_last  = (r_idx == r_len);
    // Timer reaches zero on this cycle's decrement.
    assign w_expire     = (r_timer <= TIMER_W'(1));
    assign w_retry_done = (r_retry >= RETRY_W'(MAX_RETRY));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= TX_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_req_ready  = 1'b0;
        w_data_ready = 1'b0;
        w_flit_valid = 1'b0;
        w_done       = 1'b0;
        case (r_fsm)
            TX_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_fsm_nxt = w_len_ok ? TX_LOAD : TX_FINISH;
                end
            end
            TX_LOAD: begin
                w_data_ready = 1'b1;
                if (data_valid && w_load_last) begin
                    w_fsm_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                w_flit_valid = 1'b1;
                if (flit_out_ready && w_send_last) begin
                    w_fsm_nxt = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                // A matching ACK beats a simultaneous timeout.
                if (w_ack_match) begin
                    w_fsm_nxt = TX_FINISH;
                end else if (w_expire) begin
                    w_fsm_nxt = w_retry_done ? TX_FINISH : TX_SEND;
                end
            end
            TX_FINISH: begin
                w_done    = 1'b1;
                w_fsm_nxt = TX_IDLE;
            end
            default: begin
                w_fsm_nxt = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet context, flit index, ACK timer, retry count, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dst   <= '0;
            r_pid   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_retry <= '0;
            r_sig   <= NO_ERROR;
        end else begin
            case (r_fsm)
                TX_IDLE: begin
                    if (req_valid) begin
                        r_dst   <= req_dst_id;
                        r_pid   <= req_packet_id;
                        r_len   <= req_length[2:0];
                        r_idx   <= '0;
                        r_retry <= '0;
                        r_sig   <= w_len_ok ? NO_ERROR : GENERAL_FATAL_ERROR;
                    end
                end
                TX_LOAD: begin
                    if (data_valid) begin
                        r_idx <= w_load_last ? 3'd0 : r_idx + 3'd1;
                    end
                end
                TX_SEND: begin
                    if (flit_out_ready) begin
                        if (w_send_last) begin
                            r_idx   <= '0;
                            r_timer <= TIMER_W'(ACK_TIMEOUT);
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                TX_WAIT_ACK: begin
                    r_timer <= r_timer - TIMER_W'(1);
                    if (w_ack_match) begin
                        r_sig <= NO_ERROR;
                    end else if (w_expire) begin
                        if (w_retry_done) begin
                            r_sig <= TX_NOT_REACHABLE;
                        end else begin
                            r_retry <= r_retry + RETRY_W'(1);
                            r_idx   <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Payload buffer: contents are meaningless after reset, so no reset.
    always_ff @(posedge clk) begin
        if (r_fsm == TX_LOAD && data_valid) begin
            r_buf[r_idx] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Outgoing flit assembly (checksum field left zero, filled below)
    // ------------------------------------------------------------------
    always_comb begin
        w_head               = '0;
        w_head.global_src_id = NODE_ID;
        w_head.global_dst_id = r_dst;
        w_head.length        = {5'd0, r_len};
        w_head.vc            = 8'd0;
        w_head.header        = H_NORMAL;
        w_head.option_flag   = 1'b0;
        w_head.options       = '0;

        w_flit               = '0;
        w_flit.hdr.version   = VERSION;
        w_flit.hdr.is_ack    = 1'b0;
        w_flit.hdr.src_id    = NODE_ID;
        w_flit.hdr.dst_id    = r_dst;
        w_flit.hdr.packet_id = r_pid;
        w_flit.hdr.flit_num  = {5'd0, r_idx};
        if (r_idx == 3'd0) begin
            w_flit.hdr.flittype = FT_HEAD;
            w_flit.payload      = w_head;
        end else begin
            w_flit.hdr.flittype = w_send_last ? FT_TAIL : FT_BODY;
            w_flit.payload      = r_buf[r_idx - 3'd1];
        end
    end

    flit_checksum_calc u_tx_cks (
        .i_flit     (w_flit),
        .o_checksum (w_flit_cks)
    );

    // ------------------------------------------------------------------
    // ACK matching
    // ------------------------------------------------------------------
    assign w_ack = ack_flit;

    flit_checksum_calc u_ack_cks (
        .i_flit     (w_ack),
        .o_checksum (w_ack_cks)
    );

    assign w_ack_match = (r_fsm == TX_WAIT_ACK) && ack_valid &&
                         w_ack.hdr.is_ack &&
                         (w_ack.hdr.dst_id == NODE_ID) &&
                         (w_ack.hdr.src_id == r_dst) &&
                         (w_ack.hdr.packet_id == r_pid) &&
                         (w_ack_cks == w_ack.checksum);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // req_ready is forced low while rst is held, even though IDLE is entered.
    assign req_ready      = w_req_ready && !rst;
    assign data_ready     = w_data_ready;
    assign flit_out_valid = w_flit_valid;
    assign flit_out       = w_flit_valid ? {w_flit[FLIT_W-1:CHECKSUM_W], w_flit_cks}
                                         : '0;
    assign done           = w_done;
    assign tx_signal      = r_sig;
    assign dbg_fsm        = r_fsm;

    always_comb begin
        state = NORMAL;
        if (r_fsm == TX_WAIT_ACK) begin
            state = WAIT_ACK;
        end else if (r_fsm == TX_FINISH && r_sig != NO_ERROR) begin
            state = ERROR;
        end
    end

endmodule

// File: tb/tb_flit_packet_tx.sv
module tb_flit_packet_tx;

    localparam logic [7:0] NODE = 8'h01;
    localparam logic [3:0] ST_NORMAL = 4'd0;
    localparam logic [3:0] ST_WAIT   = 4'd1;
    localparam logic [3:0] ST_ERROR  = 4'd2;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_dst_id;
    logic [7:0]   req_packet_id;
    logic [7:0]   req_length;
    logic         data_valid;
    logic         data_ready;
    logic [71:0]  data;
    logic         flit_out_valid;
    logic         flit_out_ready;
    logic [127:0] flit_out;
    logic         ack_valid;
    logic [127:0] ack_flit;
    logic         done;
    logic [31:0]  tx_signal;
    logic [3:0]   state;
    logic [2:0]   dbg_fsm;

    logic [127:0] exp_q[$];
    logic [71:0]  words [7];
    int           n_checks;
    int           n_pass;

    flit_packet_tx #(
        .NODE_ID     (NODE),
        .VERSION     (3'd1),
        .ACK_TIMEOUT (16),
        .MAX_RETRY   (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dst_id     (req_dst_id),
        .req_packet_id  (req_packet_id),
        .req_length     (req_length),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data           (data),
        .flit_out_valid (flit_out_valid),
        .flit_out_ready (flit_out_ready),
        .flit_out       (flit_out),
        .ack_valid      (ack_valid),
        .ack_flit       (ack_flit),
        .done           (done),
        .tx_signal      (tx_signal),
        .state          (state),
        .dbg_fsm        (dbg_fsm)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cks(input logic [127:0] f);
        logic [15:0] c;
        c = 16'h0;
        for (int s = 0; s < 7; s++) c = c ^ f[16*(s+1) +: 16];
        return c;
    endfunction

    function automatic logic [127:0] exp_flit(input int i, input logic [7:0] dst,
                                              input logic [7:0] pid, input logic [7:0] len);
        logic [1:0]   ft;
        logic [39:0]  hdr;
        logic [71:0]  pl;
        logic [127:0] f;
        ft  = (i == 0) ? 2'd0 : ((i == int'(len)) ? 2'd2 : 2'd1);
        hdr = {3'd1, 1'b0, ft, 2'b00, NODE, dst, pid, 8'(i)};
        if (i == 0) pl = {NODE, dst, len, 8'h00, 8'h00, 1'b0, 31'h0};
        else        pl = words[i-1];
        f = {hdr, pl, 16'h0};
        f[15:0] = cks(f);
        return f;
    endfunction

    function automatic logic [127:0] mk_ack(input logic is_ack, input logic [7:0] src,
                                            input logic [7:0] dst, input logic [7:0] pid,
                                            input logic bad);
        logic [127:0] f;
        f = {3'd1, is_ack, 2'd3, 2'b00, src, dst, pid, 8'h00, 72'h0, 16'h0};
        f[15:0] = cks(f) ^ (bad ? 16'h0001 : 16'h0000);
        return f;
    endfunction

    task automatic push_packet(input logic [7:0] dst, input logic [7:0] pid, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(exp_flit(i, dst, pid, len));
    endtask

    // ---------------- drivers ----------------
    task automatic do_req(input logic [7:0] dst, input logic [7:0] pid, input logic [7:0] len);
        bit ok;
        int cyc;
        ok = 0; cyc = 0;
        req_valid = 1'b1; req_dst_id = dst; req_packet_id = pid; req_length = len;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        if (!ok) check("req_timeout", 0, 1);
    endtask

    task automatic send_data(input int n);
        for (int j = 0; j < n; j++) begin
            bit ok;
            int cyc;
            ok = 0; cyc = 0;
            data_valid = 1'b1; data = words[j];
            while (!ok && cyc < 20) begin
                @(negedge clk);
                ok = data_ready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!ok) check("data_timeout", 0, 1);
        end
        data_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle);
        int got;
        int cyc;
        got = 0; cyc = 0;
        while (got < n && cyc < 600) begin
            flit_out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (flit_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", flit_out, 128'h0);
                end else if (flit_out_ready) begin
                    check("flit", flit_out, exp_q.pop_front());
                    check("flit_cks", {112'h0, flit_out[15:0]}, {112'h0, cks(flit_out)});
                    got++;
                end else begin
                    check("stall_hold", flit_out, exp_q[0]);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        flit_out_ready = 1'b1;
        if (got < n) check("collect_timeout", got, n);
    endtask

    task automatic send_ack(input logic [127:0] f);
        ack_valid = 1'b1; ack_flit = f;
        @(posedge clk); #1;
        ack_valid = 1'b0; ack_flit = '0;
    endtask

    task automatic expect_wait_ack();
        @(negedge clk);
        check("state_wait_ack", state, ST_WAIT);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input logic [31:0] exp_sig, input logic [3:0] exp_state);
        bit seen;
        bit flit_seen;
        int cyc;
        seen = 0; flit_seen = 0; cyc = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (flit_out_valid) flit_seen = 1;
            if (done) begin
                seen = 1;
                check("done_sig", tx_signal, exp_sig);
                check("done_state", state, exp_state);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!seen) check("done_timeout", 0, 1);
        check("no_stray_flit", flit_seen, 0);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("sig_sticky", tx_signal, exp_sig);
        check("idle_req_ready", req_ready, 1);
        check("idle_state", state, ST_NORMAL);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        req_valid = 0; req_dst_id = 0; req_packet_id = 0; req_length = 0;
        data_valid = 0; data = 0; flit_out_ready = 1; ack_valid = 0; ack_flit = 0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_flit_valid", flit_out_valid, 0);
        check("rst_flit_out", flit_out, 0);
        check("rst_done", done, 0);
        check("rst_tx_signal", tx_signal, 0);
        check("rst_state", state, ST_NORMAL);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", req_ready, 1);
        @(posedge clk); #1;

        // T1: length 3, ready always high, hand-computed HEAD
        words[0] = 72'h11_2233_4455_6677_8899;
        words[1] = 72'hAA_BBCC_DDEE_FF00_1122;
        words[2] = 72'h0F_0E0D_0C0B_0A09_0807;
        exp_q.push_back(128'h2001_052A_0001_0503_0000_0000_0000_2029);
        for (int i = 1; i <= 3; i++) exp_q.push_back(exp_flit(i, 8'h05, 8'h2A, 8'd3));
        do_req(8'h05, 8'h2A, 8'd3);
        send_data(3);
        collect(4, 1'b0);
        expect_wait_ack();
        send_ack(mk_ack(1'b1, 8'h05, NODE, 8'h2A, 1'b0));
        wait_done(32'h0, ST_NORMAL);

        // T2: backpressure 1010 during SEND
        words[0] = 72'h12_3456_789A_BCDE_F012;
        words[1] = 72'hFE_DCBA_9876_5432_10FE;
        words[2] = 72'h80_0000_0000_0000_0001;
        push_packet(8'h07, 8'h2C, 8'd3);
        do_req(8'h07, 8'h2C, 8'd3);
        send_data(3);
        collect(4, 1'b1);
        send_ack(mk_ack(1'b1, 8'h07, NODE, 8'h2C, 1'b0));
        wait_done(32'h0, ST_NORMAL);

        // T3: no ACK -> 4 identical transmissions then TX_NOT_REACHABLE
        words[0] = 72'h5A_5A5A_5A5A_5A5A_5A5A;
        words[1] = 72'hA5_A5A5_A5A5_A5A5_A5A5;
        for (int r = 0; r < 4; r++) push_packet(8'h09, 8'h30, 8'd2);
        do_req(8'h09, 8'h30, 8'd2);
        send_data(2);
        collect(12, 1'b0);
        wait_done(32'h2, ST_ERROR);

        // T4: bad ACKs ignored, retransmit, then good ACK
        words[0] = 72'h01_0203_0405_0607_0809;
        words[1] = 72'hF1_F2F3_F4F5_F6F7_F8F9;
        push_packet(8'h05, 8'h2A, 8'd2);
        do_req(8'h05, 8'h2A, 8'd2);
        send_data(2);
        collect(3, 1'b0);
        expect_wait_ack();
        send_ack(mk_ack(1'b1, 8'h05, NODE, 8'h2B, 1'b0));
        send_ack(mk_ack(1'b1, 8'h05, NODE, 8'h2A, 1'b1));
        send_ack(mk_ack(1'b0, 8'h05, NODE, 8'h2A, 1'b0));
        push_packet(8'h05, 8'h2A, 8'd2);
        collect(3, 1'b0);
        send_ack(mk_ack(1'b1, 8'h05, NODE, 8'h2A, 1'b0));
        wait_done(32'h0, ST_NORMAL);

        // T5: illegal lengths
        do_req(8'h05, 8'h40, 8'd0);
        wait_done(32'h8000_0000, ST_ERROR);
        do_req(8'h05, 8'h41, 8'd8);
        wait_done(32'h8000_0000, ST_ERROR);

        // T6: reset during BODY flit, then a length-1 packet
        words[0] = 72'hC0_FFEE_C0FF_EEC0_FFEE;
        words[1] = 72'h00_0000_0000_0000_0001;
        words[2] = 72'h00_0000_0000_0000_0002;
        push_packet(8'h03, 8'h50, 8'd3);
        do_req(8'h03, 8'h50, 8'd3);
        send_data(3);
        collect(1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_flit_valid", flit_out_valid, 0);
        check("arst_flit_out", flit_out, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_data_ready", data_ready, 0);
        check("arst_done", done, 0);
        check("arst_state", state, ST_NORMAL);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        words[0] = 72'h77_6655_4433_2211_00FF;
        push_packet(8'h0A, 8'h51, 8'd1);
        do_req(8'h0A, 8'h51, 8'd1);
        send_data(1);
        collect(2, 1'b0);
        send_ack(mk_ack(1'b1, 8'h0A, NODE, 8'h51, 1'b0));
        wait_done(32'h0, ST_NORMAL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
